// File: rtl/rd_cfg_scheduler_if.sv
// Read-request channel between the config scheduler and the read-memory port.
// The master drives the request; the slave answers with ready.
interface rd_cfg_scheduler_if #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned TX_SIZE_WIDTH = 20,
    parameter int unsigned D_TYPE_W      = 2
);
    logic                     req;
    logic                     ready;
    logic [ADDR_W-1:0]        addr;
    logic [TX_SIZE_WIDTH-1:0] req_size;
    logic [D_TYPE_W-1:0]      d_type;

    modport master (output req, addr, req_size, d_type, input ready);
    modport slave  (input req, addr, req_size, d_type, output ready);
endinterface

// File: rtl/rd_cfg_scheduler.sv
// Walks a config ROM and issues loop_max+1 strided read requests per entry.
// Fetch/load/issue per entry; start/busy/done face the PU controller.
module rd_cfg_scheduler #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned BASE_ADDR_W   = ADDR_W,
    parameter int unsigned OFFSET_ADDR_W = ADDR_W,
    parameter int unsigned TX_SIZE_WIDTH = 20,
    parameter int unsigned RD_LOOP_W     = 10,
    parameter int unsigned D_TYPE_W      = 2,
    parameter int unsigned ROM_ADDR_W    = 10,
    localparam int unsigned ROM_WIDTH    = D_TYPE_W + BASE_ADDR_W + OFFSET_ADDR_W
                                           + TX_SIZE_WIDTH + RD_LOOP_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ROM_ADDR_W:0]    num_entries,
    output logic [ROM_ADDR_W-1:0]  cfg_rom_addr,
    input  logic [ROM_WIDTH-1:0]   cfg_rom_data,
    rd_cfg_scheduler_if.master     rd,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned NUM_W    = ROM_ADDR_W + 1;
    localparam int unsigned LOOP_LSB = 0;
    localparam int unsigned SIZE_LSB = LOOP_LSB + RD_LOOP_W;
    localparam int unsigned OFF_LSB  = SIZE_LSB + TX_SIZE_WIDTH;
    localparam int unsigned BASE_LSB = OFF_LSB + OFFSET_ADDR_W;
    localparam int unsigned TYPE_LSB = BASE_LSB + BASE_ADDR_W;
    localparam logic [NUM_W-1:0] MAX_ENTRIES = {1'b1, {ROM_ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [NUM_W-1:0]         num_q, num_nxt;
    logic [ROM_ADDR_W-1:0]    idx, idx_nxt;
    logic [RD_LOOP_W-1:0]     cnt, cnt_nxt;
    logic [RD_LOOP_W-1:0]     loop_max_q, loop_nxt;
    logic [OFFSET_ADDR_W-1:0] offset_q, off_nxt;
    logic [ROM_ADDR_W-1:0]    rom_addr_nxt;
    logic [ADDR_W-1:0]        addr_nxt;
    logic [TX_SIZE_WIDTH-1:0] size_nxt;
    logic [D_TYPE_W-1:0]      type_nxt;
    logic                     req_nxt, busy_nxt, done_nxt;
    logic                     accept;
    logic                     last_entry;
    logic [ROM_ADDR_W-1:0]    idx_inc;

    assign accept     = rd.req && rd.ready;
    assign idx_inc    = idx + ROM_ADDR_W'(1);
    assign last_entry = (NUM_W'(idx) + NUM_W'(1)) == num_q;

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            num_q        <= '0;
            idx          <= '0;
            cnt          <= '0;
            loop_max_q   <= '0;
            offset_q     <= '0;
            cfg_rom_addr <= '0;
            rd.req       <= 1'b0;
            rd.addr      <= '0;
            rd.req_size  <= '0;
            rd.d_type    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            num_q        <= num_nxt;
            idx          <= idx_nxt;
            cnt          <= cnt_nxt;
            loop_max_q   <= loop_nxt;
            offset_q     <= off_nxt;
            cfg_rom_addr <= rom_addr_nxt;
            rd.req       <= req_nxt;
            rd.addr      <= addr_nxt;
            rd.req_size  <= size_nxt;
            rd.d_type    <= type_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt    = state;
        num_nxt      = num_q;
        idx_nxt      = idx;
        cnt_nxt      = cnt;
        loop_nxt     = loop_max_q;
        off_nxt      = offset_q;
        rom_addr_nxt = cfg_rom_addr;
        addr_nxt     = rd.addr;
        size_nxt     = rd.req_size;
        type_nxt     = rd.d_type;

        case (state)
            S_IDLE: begin
                if (start) begin
                    num_nxt      = (num_entries > MAX_ENTRIES) ? MAX_ENTRIES : num_entries;
                    idx_nxt      = '0;
                    rom_addr_nxt = '0;
                    state_nxt    = (num_entries == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
                type_nxt  = cfg_rom_data[TYPE_LSB +: D_TYPE_W];
                addr_nxt  = ADDR_W'(cfg_rom_data[BASE_LSB +: BASE_ADDR_W]);
                off_nxt   = cfg_rom_data[OFF_LSB +: OFFSET_ADDR_W];
                size_nxt  = cfg_rom_data[SIZE_LSB +: TX_SIZE_WIDTH];
                loop_nxt  = cfg_rom_data[LOOP_LSB +: RD_LOOP_W];
                cnt_nxt   = '0;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    if (cnt != loop_max_q) begin
                        cnt_nxt  = cnt + RD_LOOP_W'(1);
                        addr_nxt = rd.addr + ADDR_W'(offset_q);
                    end else begin
                        idx_nxt      = idx_inc;
                        rom_addr_nxt = idx_inc;
                        state_nxt    = last_entry ? S_DONE : S_FETCH;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        req_nxt  = (state_nxt == S_ISSUE);
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end
endmodule

// File: tb/tb_rd_cfg_scheduler.sv
// Randomized self-checking bench for rd_cfg_scheduler: a registered ROM model,
// a random-ready memory side and a per-entry address-list reference model.
module tb_rd_cfg_scheduler;
    localparam int unsigned AW  = 32;
    localparam int unsigned SW  = 20;
    localparam int unsigned LW  = 10;
    localparam int unsigned TW  = 2;
    localparam int unsigned RAW = 10;
    localparam int unsigned RW  = TW + AW + AW + SW + LW;
    localparam int unsigned NROM = 1 << RAW;

    typedef struct { logic [31:0] addr; logic [19:0] size; logic [1:0] typ; } req_t;
    typedef struct { logic [31:0] addr; logic [19:0] size; logic [1:0] typ; int en; } acc_t;

    logic           clk;
    logic           reset;
    logic           start;
    logic [RAW:0]   num_entries;
    logic [RAW-1:0] cfg_rom_addr;
    logic [RW-1:0]  cfg_rom_data;
    logic           busy;
    logic           done;

    rd_cfg_scheduler_if #(.ADDR_W(AW), .TX_SIZE_WIDTH(SW), .D_TYPE_W(TW)) rd_bus ();

    rd_cfg_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .num_entries(num_entries),
        .cfg_rom_addr(cfg_rom_addr), .cfg_rom_data(cfg_rom_data),
        .rd(rd_bus), .busy(busy), .done(done)
    );

    logic [1:0]  m_type [NROM];
    logic [31:0] m_base [NROM];
    logic [31:0] m_off  [NROM];
    logic [19:0] m_size [NROM];
    logic [9:0]  m_loop [NROM];
    logic [RW-1:0] rom_mem [NROM];

    req_t exp_q[$];
    acc_t acc_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   req_hi = 0;
    int   hold_viol = 0;
    int   ready_pct = 100;
    int   errors = 0;
    int   checks = 0;
    bit   busy_seen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: data one cycle after address
    always @(posedge clk) cfg_rom_data <= rom_mem[cfg_rom_addr];

    initial begin
        rd_bus.ready = 1'b0;
        forever begin
            @(negedge clk);
            rd_bus.ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: records accepts, done pulses, and any change while stalled
    initial begin
        bit stall_p;
        logic [31:0] pa;
        logic [19:0] ps;
        logic [1:0]  pt;
        stall_p = 1'b0;
        pa = '0; ps = '0; pt = '0;
        forever begin
            @(posedge clk);
            if (reset) stall_p = 1'b0;
            else begin
                if (stall_p && (rd_bus.req !== 1'b1 || rd_bus.addr !== pa ||
                                rd_bus.req_size !== ps || rd_bus.d_type !== pt))
                    hold_viol++;
                if (rd_bus.req === 1'b1) req_hi++;
                if (rd_bus.req === 1'b1 && rd_bus.ready === 1'b1)
                    acc_q.push_back('{rd_bus.addr, rd_bus.req_size, rd_bus.d_type, cyc});
                if (done === 1'b1) done_q.push_back(cyc);
                stall_p = (rd_bus.req === 1'b1) && (rd_bus.ready !== 1'b1);
                pa = rd_bus.addr; ps = rd_bus.req_size; pt = rd_bus.d_type;
            end
            cyc++;
        end
    end

    task automatic set_entry(input int i, input logic [1:0] t, input logic [31:0] b,
                             input logic [31:0] o, input logic [19:0] s, input logic [9:0] l);
        m_type[i] = t; m_base[i] = b; m_off[i] = o; m_size[i] = s; m_loop[i] = l;
        rom_mem[i] = {t, b, o, s, l};
    endtask

    // Reference: each entry expands to base + k*offset for k = 0..loop_max
    function automatic void build_model(input int n);
        int ne;
        ne = (n > int'(NROM)) ? int'(NROM) : n;
        exp_q.delete();
        for (int e = 0; e < ne; e++) begin
            for (int k = 0; k <= int'(m_loop[e]); k++) begin
                req_t r;
                r.addr = 32'(64'(m_base[e]) + 64'(k) * 64'(m_off[e]));
                r.size = m_size[e];
                r.typ  = m_type[e];
                exp_q.push_back(r);
            end
        end
    endfunction

    task automatic clear_log();
        acc_q.delete();
        done_q.delete();
        req_hi = 0;
        hold_viol = 0;
    endtask

    task automatic run_sweep(input int n, output int s_edge, output bit ok);
        @(negedge clk);
        clear_log();
        num_entries = 11'(n);
        start = 1'b1;
        s_edge = cyc;
        @(negedge clk);
        start = 1'b0;
        busy_seen = busy;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_entries = '0;
        repeat (3) @(negedge clk);
        checks++; if (rd_bus.req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", rd_bus.req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (cfg_rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", cfg_rom_addr); end
        checks++; if (rd_bus.addr !== '0 || rd_bus.req_size !== '0 || rd_bus.d_type !== '0) begin
            errors++; $display("FAIL reset_bus got addr=%h size=%h type=%h exp all 0",
                               rd_bus.addr, rd_bus.req_size, rd_bus.d_type);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_entry();
        int s; bit ok;
        ready_pct = 100;
        set_entry(0, 2'd1, 32'h1000, 32'h40, 20'd16, 10'd3);
        run_sweep(1, s, ok);
        build_model(1);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got no done exp done"); end
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL single_busy_early got=%b exp=1", busy_seen); end
        checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL single_count got=%0d exp=4", acc_q.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].addr !== exp_q[i].addr || acc_q[i].size !== exp_q[i].size ||
                acc_q[i].typ !== exp_q[i].typ || acc_q[i].en != s + 3 + i) begin
                errors++;
                $display("FAIL single_req[%0d] got addr=%h size=%0d type=%0d edge=%0d exp addr=%h size=%0d type=%0d edge=%0d",
                         i, acc_q[i].addr, acc_q[i].size, acc_q[i].typ, acc_q[i].en - s,
                         exp_q[i].addr, exp_q[i].size, exp_q[i].typ, 3 + i);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != s + 7) begin
            errors++; $display("FAIL single_done got count=%0d edge=%0d exp count=1 edge=7",
                               done_q.size(), (done_q.size() > 0) ? done_q[0] - s : -1);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_two_entries();
        int s; bit ok;
        int exp_en[3];
        logic [31:0] exp_a[3];
        ready_pct = 100;
        set_entry(0, 2'd2, 32'h0,   32'h10, 20'd8,  10'd0);
        set_entry(1, 2'd3, 32'h200, 32'h10, 20'd32, 10'd1);
        run_sweep(2, s, ok);
        exp_en = '{s + 3, s + 6, s + 7};
        exp_a  = '{32'h0, 32'h200, 32'h210};
        checks++; if (!ok || acc_q.size() != 3) begin
            errors++; $display("FAIL two_count got=%0d ok=%0d exp=3 ok=1", acc_q.size(), ok);
        end
        for (int i = 0; i < 3 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].addr !== exp_a[i] || acc_q[i].en != exp_en[i] ||
                acc_q[i].typ !== ((i == 0) ? 2'd2 : 2'd3) ||
                acc_q[i].size !== ((i == 0) ? 20'd8 : 20'd32)) begin
                errors++;
                $display("FAIL two_req[%0d] got addr=%h edge=%0d type=%0d size=%0d exp addr=%h edge=%0d",
                         i, acc_q[i].addr, acc_q[i].en - s, acc_q[i].typ, acc_q[i].size,
                         exp_a[i], exp_en[i] - s);
            end
        end
    endtask

    task automatic test_backpressure();
        int s; bit ok;
        ready_pct = 50;
        set_entry(0, 2'd1, 32'h1000, 32'h40, 20'd16, 10'd3);
        run_sweep(1, s, ok);
        build_model(1);
        checks++; if (!ok || acc_q.size() != 4) begin
            errors++; $display("FAIL bp_count got=%0d exp=4", acc_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].addr !== exp_q[i].addr || acc_q[i].size !== exp_q[i].size ||
                acc_q[i].typ !== exp_q[i].typ) begin
                errors++; $display("FAIL bp_req[%0d] got addr=%h exp addr=%h", i, acc_q[i].addr, exp_q[i].addr);
            end
        end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got=%0d changes exp=0", hold_viol); end
        checks++;
        if (done_q.size() != 1 || acc_q.size() == 0 || done_q[0] != acc_q[acc_q.size() - 1].en + 1) begin
            errors++; $display("FAIL bp_done got count=%0d exp 1 pulse one cycle after last accept", done_q.size());
        end
        ready_pct = 100;
    endtask

    task automatic test_zero_and_busy_start();
        int s; bit ok;
        ready_pct = 100;
        run_sweep(0, s, ok);
        checks++;
        if (!ok || done_q.size() != 1 || done_q[0] != s + 1) begin
            errors++; $display("FAIL zero_done got count=%0d edge=%0d exp count=1 edge=1",
                               done_q.size(), (done_q.size() > 0) ? done_q[0] - s : -1);
        end
        checks++; if (req_hi != 0) begin errors++; $display("FAIL zero_req got=%0d exp=0", req_hi); end

        set_entry(0, 2'd1, 32'h1000, 32'h40, 20'd16, 10'd3);
        ready_pct = 0;
        @(negedge clk);
        clear_log();
        num_entries = 11'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rd_bus.req !== 1'b1 || rd_bus.addr !== 32'h1000 || acc_q.size() != 0) begin
            errors++; $display("FAIL stall_state got busy=%b req=%b addr=%h acc=%0d exp 1 1 00001000 0",
                               busy, rd_bus.req, rd_bus.addr, acc_q.size());
        end
        num_entries = 11'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        ready_pct = 100;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_q.size() > 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (!ok || acc_q.size() != 4 || done_q.size() != 1) begin
            errors++; $display("FAIL busy_start got acc=%0d done=%0d exp acc=4 done=1", acc_q.size(), done_q.size());
        end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL stall_hold got=%0d exp=0", hold_viol); end
        checks++;
        if (acc_q.size() == 4 && acc_q[3].addr !== 32'h10C0) begin
            errors++; $display("FAIL stall_last got=%h exp=000010c0", acc_q[3].addr);
        end
    endtask

    task automatic test_wrap();
        int s; bit ok;
        logic [31:0] exp_a[4];
        ready_pct = 100;
        set_entry(0, 2'd0, 32'hFFFF_FFE0, 32'h10, 20'd4, 10'd3);
        run_sweep(1, s, ok);
        exp_a = '{32'hFFFF_FFE0, 32'hFFFF_FFF0, 32'h0, 32'h10};
        checks++; if (!ok || acc_q.size() != 4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", acc_q.size()); end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].addr !== exp_a[i]) begin
                errors++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, acc_q[i].addr, exp_a[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int s; bit ok;
        ready_pct = 100;
        set_entry(0, 2'd1, 32'h3000, 32'h8, 20'd4, 10'd3);
        set_entry(1, 2'd2, 32'h5000, 32'h4, 20'd6, 10'd1);
        @(negedge clk);
        clear_log();
        num_entries = 11'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && acc_q.size() < 2; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_bus.req !== 1'b0 || busy !== 1'b0 || acc_q.size() != 2) begin
            errors++; $display("FAIL mid_reset got req=%b busy=%b acc=%0d exp req=0 busy=0 acc=2",
                               rd_bus.req, busy, acc_q.size());
        end
        checks++;
        if (rd_bus.addr !== '0 || cfg_rom_addr !== '0) begin
            errors++; $display("FAIL mid_reset_regs got addr=%h rom=%h exp 0 0", rd_bus.addr, cfg_rom_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        reset = 1'b1; start = 1'b1; num_entries = 11'd1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_hi != 0) begin
            errors++; $display("FAIL reset_vs_start got busy=%b req_cycles=%0d exp 0 0", busy, req_hi);
        end
        run_sweep(2, s, ok);
        build_model(2);
        checks++; if (!ok || acc_q.size() != 6) begin errors++; $display("FAIL replay_count got=%0d exp=6", acc_q.size()); end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].addr !== exp_q[i].addr || acc_q[i].typ !== exp_q[i].typ ||
                acc_q[i].size !== exp_q[i].size) begin
                errors++; $display("FAIL replay_req[%0d] got addr=%h exp addr=%h", i, acc_q[i].addr, exp_q[i].addr);
            end
        end
    endtask

    task automatic test_random();
        int s; bit ok; int n;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 4);
            for (int e = 0; e < n; e++)
                set_entry(e, 2'($urandom), 32'($urandom), 32'($urandom_range(0, 4096)),
                          20'($urandom), 10'($urandom_range(0, 6)));
            ready_pct = $urandom_range(30, 100);
            run_sweep(n, s, ok);
            build_model(n);
            checks++;
            if (!ok || acc_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, acc_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
                checks++;
                if (acc_q[i].addr !== exp_q[i].addr || acc_q[i].size !== exp_q[i].size ||
                    acc_q[i].typ !== exp_q[i].typ) begin
                    errors++;
                    $display("FAIL rand%0d_req[%0d] got addr=%h size=%h type=%0d exp addr=%h size=%h type=%0d",
                             it, i, acc_q[i].addr, acc_q[i].size, acc_q[i].typ,
                             exp_q[i].addr, exp_q[i].size, exp_q[i].typ);
                end
            end
            checks++;
            if (hold_viol != 0 || done_q.size() != 1 || acc_q.size() == 0 ||
                done_q[0] != acc_q[acc_q.size() - 1].en + 1) begin
                errors++; $display("FAIL rand%0d_done got hold=%0d done=%0d exp hold=0 done=1 after last accept",
                                   it, hold_viol, done_q.size());
            end
        end
        ready_pct = 100;
    endtask

    task automatic test_boundaries();
        int s; bit ok;
        ready_pct = 100;
        set_entry(0, 2'd3, 32'h100, 32'h4, 20'hFFFFF, 10'h3FF);
        run_sweep(1, s, ok);
        checks++;
        if (!ok || acc_q.size() != 1024 || acc_q[acc_q.size() - 1].addr !== 32'h10FC ||
            acc_q[acc_q.size() - 1].en != s + 3 + 1023) begin
            errors++; $display("FAIL maxloop got count=%0d exp count=1024 last=000010fc back-to-back", acc_q.size());
        end
        for (int e = 0; e < int'(NROM); e++)
            set_entry(e, 2'(e), 32'(e * 256), 32'h0, 20'(e), 10'd0);
        run_sweep(2000, s, ok);
        build_model(2000);
        checks++;
        if (!ok || acc_q.size() != exp_q.size() || done_q.size() != 1) begin
            errors++; $display("FAIL clamp_count got=%0d done=%0d exp=%0d done=1", acc_q.size(), done_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i].addr !== exp_q[i].addr || acc_q[i].size !== exp_q[i].size ||
                acc_q[i].typ !== exp_q[i].typ) begin
                errors++; $display("FAIL clamp_req[%0d] got addr=%h exp addr=%h", i, acc_q[i].addr, exp_q[i].addr);
            end
        end
    endtask

    initial begin
        for (int e = 0; e < int'(NROM); e++) set_entry(e, 2'd0, 32'h0, 32'h0, 20'd0, 10'd0);
        test_reset();
        test_single_entry();
        test_two_entries();
        test_backpressure();
        test_zero_and_busy_start();
        test_wrap();
        test_reset_mid();
        test_random();
        test_boundaries();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
